hazard_scoreboard: RTL

Parametrised register-hazard tracker for the decode stage. It records the destination registers of every instruction in flight, up to STAGES stages deep with NTGT targets per instruction (a primary result plus a pre/post-increment base writeback). Each cycle it compares the decoding instruction's NSRC source registers against those records. From that comparison it decides whether decode must stall, or names the in-flight stage and port a source should be forwarded from. It replaces the fixed two-stage, two-target stall compare in decode with a configurable depth, a forwarding point and a performance counter.

---
 rtl/hazard_scoreboard_if.sv | 39 +++
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_if
// Description : Decode-side bundle for the register hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int REG_W  = 5,
    parameter int NSRC   = 2,
    parameter int NTGT   = 2,
    parameter int STAGES = 3,
    parameter int CNT_W  = 32
);
    localparam int c_stage_w = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int c_port_w  = (NTGT > 1) ? $clog2(NTGT) : 1;

    logic                      halt;
    logic                      flush;
    logic                      in_valid;
    logic [NSRC*REG_W-1:0]     in_src;
    logic [NTGT*REG_W-1:0]     in_tgt;
    logic                      stall;
    logic                      issue_valid;
    logic [NSRC-1:0]           fwd_hit;
    logic [NSRC*c_stage_w-1:0] fwd_stage;
    logic [NSRC*c_port_w-1:0]  fwd_port;
    logic [CNT_W-1:0]          stall_count;

    modport master (
        output halt, flush, in_valid, in_src, in_tgt,
        input  stall, issue_valid, fwd_hit, fwd_stage, fwd_port, stall_count
    );

    modport slave (
        input  halt, flush, in_valid, in_src, in_tgt,
        output stall, issue_valid, fwd_hit, fwd_stage, fwd_port, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Tracks in-flight destination registers and decides stall or
//               forwarding source for each decode source operand.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_W     = 5,
    parameter int NSRC      = 2,
    parameter int NTGT      = 2,
    parameter int STAGES    = 3,
    parameter int FWD_STAGE = 1,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_scoreboard_if.slave sb
);
    localparam int c_stage_w = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int c_port_w  = (NTGT > 1) ? $clog2(NTGT) : 1;

    logic                      r_valid [STAGES];
    logic [NTGT*REG_W-1:0]     r_tag   [STAGES];
    logic [CNT_W-1:0]          r_count;

    logic [NSRC-1:0]           w_any;
    logic [NSRC-1:0]           w_mblk;
    logic [c_stage_w-1:0]      w_ms [NSRC];
    logic [c_port_w-1:0]       w_mp [NSRC];
    logic [NSRC-1:0]           w_blk;
    logic [NSRC-1:0]           w_hit;
    logic [NSRC*c_stage_w-1:0] w_fwd_stage;
    logic [NSRC*c_port_w-1:0]  w_fwd_port;
    logic                      w_stall;
    logic                      w_issue;

    // Scan oldest-to-youngest so the youngest, lowest-port match is the one left standing.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            w_any[i]  = 1'b0;
            w_mblk[i] = 1'b0;
            w_ms[i]   = '0;
            w_mp[i]   = '0;
            for (int s = STAGES - 1; s >= 0; s--) begin
                for (int p = NTGT - 1; p >= 0; p--) begin
                    if (sb.in_valid && r_valid[s]
                        && (r_tag[s][p*REG_W +: REG_W] != '0)
                        && (r_tag[s][p*REG_W +: REG_W] == sb.in_src[i*REG_W +: REG_W])) begin
                        w_any[i]  = 1'b1;
                        w_mblk[i] = (s < FWD_STAGE);
                        w_ms[i]   = c_stage_w'(s);
                        w_mp[i]   = c_port_w'(p);
                    end
                end
            end
        end
    end

    always_comb begin
        w_blk       = w_any & w_mblk;
        w_hit       = w_any & ~w_mblk;
        w_fwd_stage = '0;
        w_fwd_port  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_hit[i]) begin
                w_fwd_stage[i*c_stage_w +: c_stage_w] = w_ms[i];
                w_fwd_port[i*c_port_w +: c_port_w]    = w_mp[i];
            end
        end
        w_stall = sb.in_valid && !sb.flush && (|w_blk);
        w_issue = sb.in_valid && !w_stall && !sb.flush;
    end

    assign sb.stall       = w_stall;
    assign sb.issue_valid = w_issue;
    assign sb.fwd_hit     = w_hit;
    assign sb.fwd_stage   = w_fwd_stage;
    assign sb.fwd_port    = w_fwd_port;
    assign sb.stall_count = r_count;

    // Stalls and flushes enter stage 0 as bubbles; older entries keep moving.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_valid[s] <= 1'b0;
                r_tag[s]   <= '0;
            end
            r_count <= '0;
        end else if (!sb.halt) begin
            for (int s = STAGES - 1; s >= 1; s--) begin
                r_valid[s] <= r_valid[s-1];
                r_tag[s]   <= r_tag[s-1];
            end
            r_valid[0] <= w_issue;
            r_tag[0]   <= w_issue ? sb.in_tgt : '0;
            if (w_stall && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire
